// File: rtl/dcache_2way.sv
// rtl/dcache_2way.sv - two-way set-associative write-back data cache with beat-serial memory port
// Optional hit/miss counters are enabled by defining DCACHE_2WAY_STATS_EN.
module dcache_2way #(
  parameter int LINE_LENGTH = 4,
  parameter int NSETS       = 4,
  parameter int RV          = 16,
  parameter int PA          = 22,
  parameter int MW          = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req,
  input  logic                             wr,
  input  logic                             size,
  input  logic [PA-1:0]                    paddr,
  input  logic [RV-1:0]                    wdata,
  input  logic                             fault,
  input  logic                             flush_all,
  output logic                             ready,
  output logic [RV-1:0]                    rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [PA-$clog2(LINE_LENGTH)-1:0] mem_addr,
  output logic [MW-1:0]                    mem_wdata,
  input  logic [MW-1:0]                    mem_rdata,
  input  logic                             mem_strobe
`ifdef DCACHE_2WAY_STATS_EN
  ,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
`endif
);

  localparam int OFFB  = $clog2(LINE_LENGTH);
  localparam int IDXB  = $clog2(NSETS);
  localparam int TAGB  = PA - OFFB - IDXB;
  localparam int LINEB = LINE_LENGTH * 8;
  localparam int BEATS = LINEB / MW;
  localparam int BB    = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  state_t state, next_state;

  logic [1:0]       valid_q [NSETS];
  logic [1:0]       dirty_q [NSETS];
  logic [NSETS-1:0] lru_q;
  logic [TAGB-1:0]  tag_q   [2][NSETS];
  logic [LINEB-1:0] line_q  [2][NSETS];

  logic [BB-1:0]    beat;
  logic             flush_pend;
  logic             vic_way;
  logic [IDXB-1:0]  xfer_idx;
  logic [TAGB-1:0]  xfer_tag;

  logic [IDXB-1:0]  idx;
  logic [TAGB-1:0]  tag;
  logic [OFFB-1:0]  off;
  logic             hit0, hit1, hit, hit_way, bad, flush_now, last_beat;
  logic             access, hit_ok, miss, victim, victim_dirty;
  logic [LINEB-1:0] hit_line, store_line, vic_line, fill_line;
  logic [OFFB+2:0]  byte_pos, half_pos;

  assign idx = paddr[OFFB+IDXB-1:OFFB];
  assign tag = paddr[PA-1:OFFB+IDXB];
  assign off = paddr[OFFB-1:0];

  assign hit0      = valid_q[idx][0] && (tag_q[0][idx] == tag);
  assign hit1      = valid_q[idx][1] && (tag_q[1][idx] == tag);
  assign hit       = hit0 || hit1;
  assign hit_way   = hit1;
  assign bad       = fault || (size && paddr[0]);
  assign flush_now = flush_all || flush_pend;
  assign last_beat = (beat == BB'(BEATS - 1));

  // A pending or fresh flush wins over any lookup in IDLE.
  assign access = (state == IDLE) && !flush_now && req && !bad;
  assign hit_ok = access && hit;
  assign miss   = access && !hit;

  always_comb begin
    if (!valid_q[idx][0])      victim = 1'b0;
    else if (!valid_q[idx][1]) victim = 1'b1;
    else                       victim = lru_q[idx];
  end
  assign victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];

  assign byte_pos = {off, 3'b000};
  assign half_pos = {off & ~OFFB'(1), 3'b000};
  assign hit_line = line_q[hit_way][idx];
  assign vic_line = line_q[vic_way][xfer_idx];

  always_comb begin
    store_line = hit_line;
    if (size) store_line[half_pos +: 16] = wdata[15:0];
    else      store_line[byte_pos +: 8]  = wdata[7:0];
  end

  always_comb begin
    fill_line = vic_line;
    fill_line[int'(beat) * MW +: MW] = mem_rdata;
  end

  always_comb begin
    rdata = '0;
    if (size) rdata[15:0] = hit_line[half_pos +: 16];
    else      rdata[7:0]  = hit_line[byte_pos +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss) next_state = victim_dirty ? WB : FILL;
      WB:      if (mem_strobe && last_beat) next_state = FILL;
      FILL:    if (mem_strobe && last_beat) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {xfer_tag, xfer_idx};
    mem_wdata = vic_line[int'(beat) * MW +: MW];
    case (state)
      IDLE: ready = !flush_now && req && (bad || hit);
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_q[vic_way][xfer_idx], xfer_idx};
      end
      FILL:    mem_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat       <= '0;
      flush_pend <= 1'b0;
      vic_way    <= 1'b0;
      xfer_idx   <= '0;
      xfer_tag   <= '0;
      lru_q      <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
    end else if (state == IDLE) begin
      if (flush_now) begin
        flush_pend <= 1'b0;
        lru_q      <= '0;
        for (int s = 0; s < NSETS; s++) begin
          valid_q[s] <= 2'b00;
          dirty_q[s] <= 2'b00;
        end
      end else if (hit_ok) begin
        lru_q[idx] <= ~hit_way;
        if (wr) dirty_q[idx][hit_way] <= 1'b1;
      end else if (miss) begin
        vic_way  <= victim;
        xfer_idx <= idx;
        xfer_tag <= tag;
        beat     <= '0;
      end
    end else begin
      if (flush_all) flush_pend <= 1'b1;
      if (mem_strobe) begin
        beat <= last_beat ? '0 : beat + 1'b1;
        if (state == FILL && last_beat) begin
          valid_q[xfer_idx][vic_way] <= 1'b1;
          dirty_q[xfer_idx][vic_way] <= 1'b0;
        end
      end
    end
  end

  // Line and tag storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (hit_ok && wr) line_q[hit_way][idx] <= store_line;
    if (state == FILL && mem_strobe) begin
      line_q[vic_way][xfer_idx] <= fill_line;
      if (last_beat) tag_q[vic_way][xfer_idx] <= xfer_tag;
    end
  end

`ifdef DCACHE_2WAY_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_ok && hit_count != 16'hFFFF)  hit_count  <= hit_count + 16'd1;
      if (miss && miss_count != 16'hFFFF)   miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// tb/tb_dcache_2way.sv - self-checking bench for dcache_2way
module tb_dcache_2way;
  localparam int BEATS = 8;
  localparam int NV    = 20;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req = 1'b0, wr = 1'b0, size = 1'b0, fault = 1'b0, flush_all = 1'b0;
  logic        mem_strobe = 1'b0;
  logic [21:0] paddr = '0;
  logic [15:0] wdata = '0;
  logic [3:0]  mem_rdata = '0;
  logic        ready, mem_req, mem_we;
  logic [15:0] rdata;
  logic [19:0] mem_addr;
  logic [3:0]  mem_wdata;
`ifdef DCACHE_2WAY_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int flush_beat = -1;
  logic [7:0] bmem [1024];
  logic [7:0] gold [1024];

  typedef struct {
    logic        w;
    logic        sz;
    logic [21:0] addr;
    logic [15:0] wd;
    logic        flt;
    logic        imm;
    logic [15:0] rd;
    logic        wb;
    logic [19:0] wba;
    logic [31:0] wbl;
  } vec_t;

  always #5 clk = ~clk;

  dcache_2way dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .size(size), .paddr(paddr),
    .wdata(wdata), .fault(fault), .flush_all(flush_all), .ready(ready), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_strobe(mem_strobe)
`ifdef DCACHE_2WAY_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  function automatic logic [7:0] f(input int a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [15:0] h(input int a);
    return {f(a + 1), f(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req = 1'b0; flush_all = 1'b0; mem_strobe = 1'b0; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Drives one access and plays the memory side until ready, with random strobe gaps.
  task automatic run_op(input logic w, input logic sz, input logic [21:0] a, input logic [15:0] wd,
                        input logic flt, output int cyc, output logic [15:0] rd, output logic wb,
                        output logic [19:0] wba, output logic [31:0] wbl, output int fills,
                        output logic timeout);
    int bb;
    int bi;
    logic prev_fill;
    cyc = 0; rd = '0; wb = 1'b0; wba = '0; wbl = '0; fills = 0; timeout = 1'b1;
    bb = 0; prev_fill = 1'b0;
    req = 1'b1; wr = w; size = sz; paddr = a; wdata = wd; fault = flt;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      mem_strobe = 1'b0; flush_all = 1'b0;
      #1;
      if (ready) begin
        rd = rdata; timeout = 1'b0;
        break;
      end
      if (mem_req) begin
        if (!mem_we && !prev_fill) fills++;
        if (mem_we) begin wb = 1'b1; wba = mem_addr; end
        if (flush_beat >= 0 && !mem_we && fills == 1 && bb == flush_beat) flush_all = 1'b1;
        if ($urandom_range(0, 3) != 0) begin
          mem_strobe = 1'b1;
          bi = (int'(mem_addr) * 4 + bb / 2) & 1023;
          if (mem_we) begin
            wbl[bb*4 +: 4] = mem_wdata;
            if (bb % 2 == 1) bmem[bi][7:4] = mem_wdata;
            else             bmem[bi][3:0] = mem_wdata;
          end else begin
            mem_rdata = (bb % 2 == 1) ? bmem[bi][7:4] : bmem[bi][3:0];
          end
          bb = (bb == BEATS - 1) ? 0 : bb + 1;
        end
      end
      prev_fill = mem_req && !mem_we;
      @(posedge clk);
      cyc++;
    end
    mem_strobe = 1'b0; flush_all = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vt [NV];
    int          cyc, fills;
    logic [15:0] rd;
    logic        wb, to, got;
    logic [19:0] wba;
    logic [31:0] wbl;
    int          lq [4][$];
    bit          ldirty [256];
    int          a, line, s, pos, vic;
    logic        rw, rsz, rflt, bad, e_imm, e_wb;
    logic [15:0] rwd, e_rd;
    logic [31:0] e_wbl;

    for (int i = 0; i < 1024; i++) bmem[i] = f(i);
    bmem[16] = 8'h11; bmem[17] = 8'h22; bmem[18] = 8'h33; bmem[19] = 8'h44;

    vt[0]  = '{1'b0, 1'b1, 22'h10, 16'h0,    1'b0, 1'b0, 16'h2211,             1'b0, 20'h0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 22'h13, 16'h0,    1'b0, 1'b1, 16'h0044,             1'b0, 20'h0, 32'h0};
    vt[2]  = '{1'b1, 1'b1, 22'h10, 16'hBEEF, 1'b0, 1'b1, 16'h0,                1'b0, 20'h0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 22'h10, 16'h0,    1'b0, 1'b1, 16'hBEEF,             1'b0, 20'h0, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 22'h30, 16'h0,    1'b0, 1'b0, h(32'h30),            1'b0, 20'h0, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 22'h50, 16'h0,    1'b0, 1'b0, h(32'h50),            1'b1, 20'h4, 32'h4433BEEF};
    vt[6]  = '{1'b0, 1'b1, 22'h10, 16'h0,    1'b0, 1'b0, 16'hBEEF,             1'b0, 20'h0, 32'h0};
    vt[7]  = '{1'b0, 1'b0, 22'h31, 16'h0,    1'b0, 1'b0, {8'h00, f(32'h31)},   1'b0, 20'h0, 32'h0};
    vt[8]  = '{1'b1, 1'b1, 22'h10, 16'h1234, 1'b1, 1'b1, 16'h0,                1'b0, 20'h0, 32'h0};
    vt[9]  = '{1'b1, 1'b1, 22'h11, 16'h5678, 1'b0, 1'b1, 16'h0,                1'b0, 20'h0, 32'h0};
    vt[10] = '{1'b0, 1'b1, 22'h10, 16'h0,    1'b0, 1'b1, 16'hBEEF,             1'b0, 20'h0, 32'h0};
    vt[11] = '{1'b0, 1'b0, 22'h12, 16'h0,    1'b0, 1'b1, 16'h0033,             1'b0, 20'h0, 32'h0};
    vt[12] = '{1'b0, 1'b0, 22'h70, 16'h0,    1'b0, 1'b0, {8'h00, f(32'h70)},   1'b0, 20'h0, 32'h0};
    vt[13] = '{1'b0, 1'b0, 22'h90, 16'h0,    1'b0, 1'b0, {8'h00, f(32'h90)},   1'b0, 20'h0, 32'h0};
    vt[14] = '{1'b0, 1'b1, 22'h08, 16'h0,    1'b0, 1'b0, h(32'h08),            1'b0, 20'h0, 32'h0};
    vt[15] = '{1'b0, 1'b1, 22'h08, 16'h0,    1'b0, 1'b1, h(32'h08),            1'b0, 20'h0, 32'h0};
    vt[16] = '{1'b0, 1'b1, 22'h28, 16'h0,    1'b0, 1'b0, h(32'h28),            1'b0, 20'h0, 32'h0};
    vt[17] = '{1'b0, 1'b1, 22'h08, 16'h0,    1'b0, 1'b1, h(32'h08),            1'b0, 20'h0, 32'h0};
    vt[18] = '{1'b1, 1'b0, 22'h29, 16'h77AB, 1'b0, 1'b1, 16'h0,                1'b0, 20'h0, 32'h0};
    vt[19] = '{1'b0, 1'b1, 22'h28, 16'h0,    1'b0, 1'b1, {8'hAB, f(32'h28)},   1'b0, 20'h0, 32'h0};

    do_reset();
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].w, vt[i].sz, vt[i].addr, vt[i].wd, vt[i].flt, cyc, rd, wb, wba, wbl, fills, to);
      chk($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
      chk($sformatf("v%0d_same_cycle", i), 32'(cyc == 0), 32'(vt[i].imm));
      if (!vt[i].w) chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vt[i].rd));
      chk($sformatf("v%0d_writeback", i), 32'(wb), 32'(vt[i].wb));
      if (vt[i].wb) begin
        chk($sformatf("v%0d_wb_addr", i), 32'(wba), 32'(vt[i].wba));
        chk($sformatf("v%0d_wb_line", i), wbl, vt[i].wbl);
      end
    end

    // Flush while idle: a previously cached line must miss afterwards.
    flush_all = 1'b1;
    @(posedge clk);
    #1 flush_all = 1'b0;
    run_op(1'b0, 1'b1, 22'h08, 16'h0, 1'b0, cyc, rd, wb, wba, wbl, fills, to);
    chk("idle_flush_miss", 32'(cyc != 0 && !to), 32'd1);
    chk("idle_flush_rdata", 32'(rd), 32'(h(32'h08)));

    // Flush raised mid-fill: fill completes, is discarded, and the held request refills.
    flush_beat = 3;
    run_op(1'b0, 1'b1, 22'h100, 16'h0, 1'b0, cyc, rd, wb, wba, wbl, fills, to);
    flush_beat = -1;
    chk("fill_flush_fills", 32'(fills), 32'd2);
    chk("fill_flush_rdata", 32'(rd), 32'(h(32'h100)));
    run_op(1'b0, 1'b1, 22'h08, 16'h0, 1'b0, cyc, rd, wb, wba, wbl, fills, to);
    chk("fill_flush_other_invalid", 32'(cyc != 0 && !to), 32'd1);
    run_op(1'b0, 1'b1, 22'h100, 16'h0, 1'b0, cyc, rd, wb, wba, wbl, fills, to);
    chk("fill_flush_refilled_hit", 32'(cyc == 0 && !to), 32'd1);

    // Reset in the middle of a writeback.
    do_reset();
    run_op(1'b1, 1'b0, 22'h00, 16'h00C3, 1'b0, cyc, rd, wb, wba, wbl, fills, to);
    run_op(1'b0, 1'b0, 22'h40, 16'h0, 1'b0, cyc, rd, wb, wba, wbl, fills, to);
    req = 1'b1; wr = 1'b0; size = 1'b0; paddr = 22'h80; fault = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (mem_req && mem_we) begin got = 1'b1; break; end
    end
    chk("rst_wb_started", 32'(got), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mem_req_drop", 32'(mem_req), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    req = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_op(1'b0, 1'b0, 22'h00, 16'h0, 1'b0, cyc, rd, wb, wba, wbl, fills, to);
    chk("rst_line_invalid", 32'(cyc != 0 && !to), 32'd1);
    chk("rst_dirty_cleared", 32'(wb), 32'd0);
    chk("rst_reload_rdata", 32'(rd), 32'(f(0)));

    // Randomised traffic against a flat-memory + true-LRU reference model.
    do_reset();
    for (int i = 0; i < 1024; i++) gold[i] = bmem[i];
    for (int i = 0; i < 256; i++) ldirty[i] = 1'b0;
    for (int i = 0; i < 4; i++) lq[i].delete();
    for (int n = 0; n < 300; n++) begin
      a    = $urandom_range(0, 127);
      rw   = 1'($urandom_range(0, 1));
      rsz  = 1'($urandom_range(0, 1));
      rflt = ($urandom_range(0, 15) == 0);
      rwd  = 16'($urandom);
      if (rsz && $urandom_range(0, 7) != 0) a = a & ~1;
      bad   = rflt || (rsz && (a % 2 == 1));
      line  = a / 4;
      s     = line % 4;
      e_imm = 1'b1; e_wb = 1'b0; e_wbl = '0; vic = 0;
      if (!bad) begin
        pos = -1;
        for (int k = 0; k < lq[s].size(); k++) if (lq[s][k] == line) pos = k;
        if (pos >= 0) begin
          lq[s].delete(pos);
        end else begin
          e_imm = 1'b0;
          if (lq[s].size() == 2) begin
            vic = lq[s][1];
            lq[s].delete(1);
            if (ldirty[vic]) begin
              e_wb  = 1'b1;
              e_wbl = {gold[vic*4+3], gold[vic*4+2], gold[vic*4+1], gold[vic*4]};
            end
          end
          ldirty[line] = 1'b0;
        end
        lq[s].push_front(line);
        if (rw) begin
          ldirty[line] = 1'b1;
          gold[a] = rwd[7:0];
          if (rsz) gold[a+1] = rwd[15:8];
        end
      end
      e_rd = rsz ? {gold[a+1], gold[a]} : {8'h00, gold[a]};
      run_op(rw, rsz, 22'(a), rwd, rflt, cyc, rd, wb, wba, wbl, fills, to);
      chk($sformatf("r%0d_timeout", n), 32'(to), 32'd0);
      chk($sformatf("r%0d_same_cycle", n), 32'(cyc == 0), 32'(e_imm));
      if (!rw && !bad) chk($sformatf("r%0d_rdata a=%0h", n, a), 32'(rd), 32'(e_rd));
      chk($sformatf("r%0d_writeback", n), 32'(wb), 32'(e_wb));
      if (e_wb) begin
        chk($sformatf("r%0d_wb_addr", n), 32'(wba), 32'(vic));
        chk($sformatf("r%0d_wb_line", n), wbl, e_wbl);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_2way.md
# dcache_2way

Two-way set-associative, write-back, write-allocate data cache for the 16-bit core, successor to the direct-mapped nibble-serial data cache. Sits between the load/store unit and the narrow external memory port; adds way selection with per-set LRU, an explicit CPU ready handshake, a parametrised memory beat width and a pending-flush mechanism. Line fill and writeback transfer one beat per `mem_strobe`.

## Interface
- `LINE_LENGTH`, 4: line size in bytes, power of 2, ≥2
- `NSETS`, 4: sets, power of 2, ≥2
- `RV`, 16: CPU data width (only 16 supported)
- `PA`, 22: physical address width
- `MW`, 4: memory beat width in bits, 4 or 8; BEATS = LINE_LENGTH*8/MW
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `req`  in  1  CPU access request; held stable with address/data until `ready`
- `wr`  in  1  1 = store, 0 = load
- `size`  in  1  0 = byte, 1 = halfword (must have `paddr[0]`=0)
- `paddr`  in  PA  byte address
- `wdata`  in  RV  store data; byte stores use `wdata[7:0]`
- `fault`  in  1  MMU fault for the current access
- `flush_all`  in  1  invalidate whole cache, no writeback
- `ready`  out  1  access completes this cycle
- `rdata`  out  RV  load data, valid only when `ready`&&!`wr`; byte loads zero-extended
- `mem_req`  out  1  memory transfer in progress
- `mem_we`  out  1  1 = writeback, 0 = fill
- `mem_addr`  out  PA-log2(LINE_LENGTH)  line address of transfer
- `mem_wdata`  out  MW  current writeback beat
- `mem_rdata`  in  MW  current fill beat
- `mem_strobe`  in  1  current beat accepted/delivered this cycle

## Operation
- Index = `paddr[log2(LINE_LENGTH*NSETS)-1:log2(LINE_LENGTH)]`; tag = bits above. Per set: two ways, each valid, dirty, tag, line; one LRU bit naming the least-recently-used way.
- States: IDLE, WB, FILL. Beat counter `beat` 0..BEATS-1.
- IDLE, `req`: if `fault` or (`size`&&`paddr[0]`) → `ready`=1, no state change. Else lookup both ways; hit → `ready`=1 combinationally; store writes selected bytes and sets dirty at the edge; LRU set to the other way. Miss → choose victim: invalid way (way 0 first), else LRU way. Victim valid&&dirty → WB, else FILL. `ready`=0.
- WB: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag,index}, `mem_wdata`=victim line bits [beat*MW+MW-1 : beat*MW]. On `mem_strobe` beat++; on last beat → FILL, beat=0.
- FILL: `mem_req`=1, `mem_we`=0, `mem_addr`={request tag,index}; on `mem_strobe` capture `mem_rdata` into beat slot. On last beat: tag written, valid=1, dirty=0, → IDLE; the held request then hits.
- Beat order: beat 0 = lowest address, low nibble/byte first.
- `flush_all` in IDLE: clears all valid, dirty, LRU at the edge; takes priority over `req` (`ready`=0 that cycle). Outside IDLE it sets a pending flag, applied on the first IDLE cycle (before any lookup); the just-filled line is then discarded.
- `req` dropped mid-transfer: transfer still completes; return to IDLE.
- `fault`, `wr`, `size` ignored outside IDLE.

## Timing
- Reset (async assert, any state): state IDLE, beat 0, all valid/dirty/LRU 0, pending flush 0; `mem_req`=0, `mem_we`=0, `ready`=0; abandons any transfer.
- Hit: `ready` same cycle as `req`. Clean miss: 1 + BEATS strobes + 1 cycles minimum. Dirty miss: adds BEATS strobes.
- `mem_addr`, `mem_we`, `mem_wdata` stable while `mem_req` and no strobe.

## Configuration
- `DCACHE_2WAY_STATS_EN` defined: adds outputs `hit_count`, `miss_count` (16 bits each, reset 0, saturate at 16'hFFFF); hit_count increments on each non-faulting hit `ready`, miss_count on each IDLE→WB/FILL transition. Undefined: ports and counters absent, behaviour otherwise identical.

## Test plan
- Reset, load halfword 0x000010 → FILL, 8 strobes (MW=4) with line 0x44332211 → `ready`, `rdata`=0x2211; next load byte 0x000013 → same-cycle `ready`, `rdata`=0x0044.
- Store 0xBEEF to 0x000010, then loads to 0x000030 and 0x000050 (same set): second miss evicts LRU dirty way → WB beats F,E,E,B,… at `mem_addr`=0x000010>>2, then FILL.
- Hit on way 0 then miss in same set → way 1 replaced, way 0 data still hits.
- `flush_all` asserted during FILL → fill completes, next cycle all invalid, held `req` misses again.
- `fault`=1 store on a hit line → `ready`=1, data and dirty unchanged; misaligned halfword same.
- Reset asserted mid-WB → `mem_req` drops immediately, all lines invalid.
